// File: rtl/board_pkg.sv
// Shared types and board geometry helpers for the card-board pair matcher.
// Cell index = row * cols + col; all helpers take the board size explicitly.
package board_pkg;

    localparam int ROWS_DEF = 6;
    localparam int COLS_DEF = 6;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_RD0,
        S_RD1,
        S_WAIT,
        S_CMP,
        S_WALK,
        S_DONE
    } state_t;

    function automatic int idx_row(input int idx, input int cols);
        return idx / cols;
    endfunction

    function automatic int idx_col(input int idx, input int cols);
        return idx % cols;
    endfunction

    // True when a card at idx cannot move further in dir because it sits on that border.
    function automatic logic on_border(input int idx, input dir_t dir, input int rows, input int cols);
        logic r;
        r = 1'b0;
        case (dir)
            DIR_UP:    r = (idx_row(idx, cols) == 0);
            DIR_RIGHT: r = (idx_col(idx, cols) == cols - 1);
            DIR_DOWN:  r = (idx_row(idx, cols) == rows - 1);
            DIR_LEFT:  r = (idx_col(idx, cols) == 0);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic int step_idx(input int idx, input dir_t dir, input int cols);
        int r;
        r = idx;
        case (dir)
            DIR_UP:    r = idx - cols;
            DIR_RIGHT: r = idx + 1;
            DIR_DOWN:  r = idx + cols;
            DIR_LEFT:  r = idx - 1;
            default:   r = idx;
        endcase
        return r;
    endfunction

    function automatic logic is_adjacent(input int a, input int b, input int cols);
        logic same_row;
        int   diff;
        same_row = (idx_row(a, cols) == idx_row(b, cols));
        diff     = (a > b) ? (a - b) : (b - a);
        return (diff == cols) || (same_row && diff == 1);
    endfunction

endpackage

// File: rtl/board_matcher_sel_decode.sv
// Combinational decode of the buffered selection vector:
// popcount saturated at 3, plus lowest and highest set index.
module sel_decode #(
    parameter int N  = 36,
    parameter int AW = 6
) (
    input  logic [N-1:0]  sel,
    output logic [1:0]    count,
    output logic [AW-1:0] first_idx,
    output logic [AW-1:0] last_idx
);

    always_comb begin
        count     = 2'd0;
        first_idx = '0;
        last_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) first_idx = AW'(i);
        end
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                last_idx = AW'(i);
                if (count != 2'd3) count = count + 2'd1;
            end
        end
    end

endmodule

// File: rtl/board_matcher.sv
// Pair matcher: checks two selected cards for equal colour and a shared reachable border.
// Optional build macro MATCHER_ADJACENT_EN: equal colours on orthogonally adjacent cells match immediately.
//
//  state  | meaning
//  IDLE   | waiting for start; buffers sel/hidden on start
//  SEL    | popcount and first/last selected index
//  RD0    | colour read of coord0
//  RD1    | colour read of coord1
//  WAIT   | waiting for colour1 to return
//  CMP    | colour compare (and adjacency shortcut when enabled)
//  WALK   | per-direction border walk, card0 then card1
//  DONE   | one-cycle ms/mf pulse
module board_matcher
    import board_pkg::*;
#(
    parameter int  ROWS   = ROWS_DEF,
    parameter int  COLS   = COLS_DEF,
    parameter int  CW     = 3,
    parameter int  RD_LAT = 1,
    localparam int N      = ROWS * COLS,
    localparam int AW     = $clog2(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  sel_bus,
    input  logic [N-1:0]  hidden_bus,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [CW-1:0] rd_color,
    output logic          busy,
    output logic          ms,
    output logic          mf,
    output logic [1:0]    match_dir,
    output logic [AW-1:0] coord0,
    output logic [AW-1:0] coord1
);

    state_t          state_q, state_d;
    logic [N-1:0]    sel_q, sel_d;
    logic [N-1:0]    hid_q, hid_d;
    logic [AW-1:0]   coord0_q, coord0_d;
    logic [AW-1:0]   coord1_q, coord1_d;
    logic [CW-1:0]   color0_q, color0_d;
    logic [CW-1:0]   color1_q, color1_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    dir_t            dir_q, dir_d;
    logic            card_q, card_d;
    logic [AW-1:0]   pos_q, pos_d;
    logic            ok_q, ok_d;

    logic [1:0]      sel_cnt;
    logic [AW-1:0]   sel_first;
    logic [AW-1:0]   sel_last;
    logic [AW-1:0]   nb_idx;
    logic            at_border;
    logic            nb_open;
    logic            rd_done0;
    logic            rd_done1;

    sel_decode #(
        .N  (N),
        .AW (AW)
    ) u_sel_decode (
        .sel       (sel_q),
        .count     (sel_cnt),
        .first_idx (sel_first),
        .last_idx  (sel_last)
    );

    assign at_border = on_border(int'(pos_q), dir_q, ROWS, COLS);
    assign nb_idx    = AW'(step_idx(int'(pos_q), dir_q, COLS));
    // The other card is never passable, even if its hidden bit is set.
    assign nb_open   = hid_q[nb_idx] && !sel_q[nb_idx];

    assign rd_done0  = vld_q[RD_LAT-1] && !tag_q[RD_LAT-1];
    assign rd_done1  = vld_q[RD_LAT-1] &&  tag_q[RD_LAT-1];

    // Read-return tracking: tag 0 marks the coord0 read, tag 1 the coord1 read.
    always_comb begin
        vld_d    = '0;
        tag_d    = '0;
        vld_d[0] = (state_q == S_RD0) || (state_q == S_RD1);
        tag_d[0] = (state_q == S_RD1);
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        color0_d = color0_q;
        color1_d = color1_q;
        if (rd_done0) color0_d = rd_color;
        if (rd_done1) color1_d = rd_color;
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        hid_d    = hid_q;
        coord0_d = coord0_q;
        coord1_d = coord1_q;
        dir_d    = dir_q;
        card_d   = card_q;
        pos_d    = pos_q;
        ok_d     = ok_q;

        case (state_q)
            S_IDLE: begin
                ok_d = 1'b0;
                if (start) begin
                    sel_d   = sel_bus;
                    hid_d   = hidden_bus;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                coord0_d = sel_first;
                coord1_d = sel_last;
                if (sel_cnt != 2'd2) begin
                    ok_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD0;
                end
            end
            S_RD0: state_d = S_RD1;
            S_RD1: state_d = S_WAIT;
            S_WAIT: begin
                if (rd_done1) state_d = S_CMP;
            end
            S_CMP: begin
                if (color0_q != color1_q) begin
                    ok_d    = 1'b0;
                    state_d = S_DONE;
                end
`ifdef MATCHER_ADJACENT_EN
                else if (is_adjacent(int'(coord0_q), int'(coord1_q), COLS)) begin
                    ok_d    = 1'b1;
                    dir_d   = DIR_UP;
                    state_d = S_DONE;
                end
`endif
                else begin
                    dir_d   = DIR_UP;
                    card_d  = 1'b0;
                    pos_d   = coord0_q;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (at_border) begin
                    if (!card_q) begin
                        card_d = 1'b1;
                        pos_d  = coord1_q;
                    end else begin
                        ok_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (nb_open) begin
                    pos_d = nb_idx;
                end else if (dir_q == DIR_LEFT) begin
                    ok_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    dir_d  = dir_t'(dir_q + 2'd1);
                    card_d = 1'b0;
                    pos_d  = coord0_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            hid_q    <= '0;
            coord0_q <= '0;
            coord1_q <= '0;
            color0_q <= '0;
            color1_q <= '0;
            vld_q    <= '0;
            tag_q    <= '0;
            dir_q    <= DIR_UP;
            card_q   <= 1'b0;
            pos_q    <= '0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            hid_q    <= hid_d;
            coord0_q <= coord0_d;
            coord1_q <= coord1_d;
            color0_q <= color0_d;
            color1_q <= color1_d;
            vld_q    <= vld_d;
            tag_q    <= tag_d;
            dir_q    <= dir_d;
            card_q   <= card_d;
            pos_q    <= pos_d;
            ok_q     <= ok_d;
        end
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (state_q == S_RD0) begin
            rd_en   = 1'b1;
            rd_addr = coord0_q;
        end else if (state_q == S_RD1) begin
            rd_en   = 1'b1;
            rd_addr = coord1_q;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign ms        = (state_q == S_DONE) &&  ok_q;
    assign mf        = (state_q == S_DONE) && !ok_q;
    assign match_dir = ms ? dir_q : 2'd0;
    assign coord0    = coord0_q;
    assign coord1    = coord1_q;

endmodule

// File: tb/tb_board_matcher.sv
// Directed bench for board_matcher: 6x6/RD_LAT=1 instance plus a 4x8/RD_LAT=3 instance for reset-abort.
module tb_board_matcher;

    localparam int ROWS  = 6;
    localparam int COLS  = 6;
    localparam int CW    = 3;
    localparam int LAT   = 1;
    localparam int N     = ROWS * COLS;
    localparam int AW    = 6;
    localparam int BOUND = 5 + LAT + 4 * (ROWS + COLS);

    localparam int R2     = 4;
    localparam int C2     = 8;
    localparam int LAT2   = 3;
    localparam int N2     = R2 * C2;
    localparam int AW2    = 5;
    localparam int BOUND2 = 5 + LAT2 + 4 * (R2 + C2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic [N-1:0]  sel_bus, hidden_bus;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_color;
    logic          busy, ms, mf;
    logic [1:0]    match_dir;
    logic [AW-1:0] coord0, coord1;

    logic           rst2, start2;
    logic [N2-1:0]  sel2, hid2;
    logic           rd_en2;
    logic [AW2-1:0] rd_addr2;
    logic [CW-1:0]  rd_color2;
    logic           busy2, ms2, mf2;
    logic [1:0]     dir2;
    logic [AW2-1:0] c20, c21;

    board_matcher #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_bus(sel_bus), .hidden_bus(hidden_bus),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_color(rd_color), .busy(busy), .ms(ms), .mf(mf),
        .match_dir(match_dir), .coord0(coord0), .coord1(coord1)
    );

    board_matcher #(.ROWS(R2), .COLS(C2), .CW(CW), .RD_LAT(LAT2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .sel_bus(sel2), .hidden_bus(hid2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_color(rd_color2), .busy(busy2), .ms(ms2), .mf(mf2),
        .match_dir(dir2), .coord0(c20), .coord1(c21)
    );

    // Colour memories with the configured read latency; idle cycles return 0.
    logic [CW-1:0] mem1 [N];
    logic [CW-1:0] mem2 [N2];
    logic [CW-1:0] pipe1;
    logic [CW-1:0] pipe2 [LAT2];

    always @(posedge clk) begin
        pipe1    <= rd_en ? mem1[rd_addr] : '0;
        pipe2[0] <= rd_en2 ? mem2[rd_addr2] : '0;
        pipe2[1] <= pipe2[0];
        pipe2[2] <= pipe2[1];
    end
    assign rd_color  = pipe1;
    assign rd_color2 = pipe2[LAT2-1];

    logic [AW-1:0] addr_q [$];
    int            addr_bad = 0;
    always @(posedge clk) if (rd_en) addr_q.push_back(rd_addr);
    always @(negedge clk) if (!rd_en && rd_addr != '0) addr_bad++;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] pair(input int a, input int b);
        logic [N-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        return v;
    endfunction

    // One operation on dut: start from a negedge, count cycles until ms/mf.
    task automatic run_op(input string name, input logic [N-1:0] s, input logic [N-1:0] h,
                          input bit poke, input logic exp_ms, input logic [1:0] exp_dir,
                          input int exp_cyc);
        int cyc;
        logic got_ms, got_mf;
        logic [1:0] got_dir;
        addr_q.delete();
        @(negedge clk);
        sel_bus    = s;
        hidden_bus = h;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        sel_bus    = '0;
        hidden_bus = '0;
        cyc        = 1;
        chk({name, "_busy"}, busy, 1);
        while (!(ms || mf) && cyc < BOUND + 4) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 3) begin
                start   = 1'b1;
                sel_bus = '1;
            end else begin
                start   = 1'b0;
                sel_bus = '0;
            end
        end
        start   = 1'b0;
        got_ms  = ms;
        got_mf  = mf;
        got_dir = match_dir;
        chk({name, "_cycles"}, cyc, exp_cyc);
        chk({name, "_ms"}, got_ms, exp_ms);
        chk({name, "_mf"}, got_mf, !exp_ms);
        chk({name, "_dir"}, got_dir, exp_dir);
        @(negedge clk);
        chk({name, "_after"}, {busy, ms, mf}, 3'b000);
    endtask

    initial begin
        logic [N-1:0] h;
        int cyc;
        int pulses;

        rst = 1'b1; rst2 = 1'b1;
        start = 1'b0; start2 = 1'b0;
        sel_bus = '0; hidden_bus = '0; sel2 = '0; hid2 = '0;
        foreach (mem1[i]) mem1[i] = '0;
        foreach (mem2[i]) mem2[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, ms, mf, rd_en, match_dir, rd_addr, coord0, coord1}, 0);
        chk("reset_outs2", {busy2, ms2, mf2, rd_en2, dir2, rd_addr2, c20, c21}, 0);
        rst = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        // Both cards already on row 0.
        mem1[0] = 3'd2; mem1[5] = 3'd2;
        run_op("t1", pair(0, 5), '0, 1'b0, 1'b1, 2'd0, 8);
        chk("t1_c0", coord0, 0);
        chk("t1_c1", coord1, 5);

        // Two-step walks up to row 0; start while busy must be ignored.
        mem1[14] = 3'd4; mem1[16] = 3'd4;
        h = '0; h[8] = 1'b1; h[2] = 1'b1; h[10] = 1'b1; h[4] = 1'b1;
        run_op("t2", pair(14, 16), h, 1'b1, 1'b1, 2'd0, 12);
        chk("t2_c0", coord0, 14);
        chk("t2_c1", coord1, 16);

        // Colour mismatch: fail straight after compare, reads at 14 then 16.
        mem1[14] = 3'd3; mem1[16] = 3'd5;
        run_op("t3", pair(14, 16), '0, 1'b0, 1'b0, 2'd0, 6);
        chk("t3_nreads", addr_q.size(), 2);
        if (addr_q.size() == 2) begin
            chk("t3_addr0", addr_q[0], 14);
            chk("t3_addr1", addr_q[1], 16);
        end

        // Wrong selection counts never read colours.
        h = '0; h[1] = 1'b1; h[2] = 1'b1; h[3] = 1'b1;
        run_op("t4", h, '0, 1'b0, 1'b0, 2'd0, 2);
        chk("t4_nreads", addr_q.size(), 0);
        chk("t4_c0", coord0, 1);
        chk("t4_c1", coord1, 3);
        run_op("t4z", '0, '0, 1'b0, 1'b0, 2'd0, 2);

        // Vertically adjacent equal cards, nothing hidden.
        mem1[14] = 3'd6; mem1[20] = 3'd6; mem1[21] = 3'd6;
`ifdef MATCHER_ADJACENT_EN
        run_op("t5", pair(14, 20), '0, 1'b0, 1'b1, 2'd0, 6);
`else
        run_op("t5", pair(14, 20), '0, 1'b0, 1'b0, 2'd0, 10);
`endif
        // Diagonal neighbours are not adjacent.
        run_op("t5d", pair(14, 21), '0, 1'b0, 1'b0, 2'd0, 10);

        // Opposite corners: each on a different border only.
        mem1[35] = 3'd2;
        run_op("t7", pair(0, 35), '0, 1'b0, 1'b0, 2'd0, 12);

        // Card1 walking left is blocked by card0 even though its cell is marked hidden.
        mem1[12] = 3'd1; mem1[14] = 3'd1;
        h = '0; h[12] = 1'b1; h[13] = 1'b1;
        run_op("t8", pair(12, 14), h, 1'b0, 1'b0, 2'd0, 13);

        // Matches found in RIGHT, DOWN, LEFT with zero steps.
        mem1[5] = 3'd7; mem1[17] = 3'd7;
        run_op("t9", pair(5, 17), '0, 1'b0, 1'b1, 2'd1, 10);
        mem1[30] = 3'd5; mem1[32] = 3'd5;
        run_op("t10", pair(30, 32), '0, 1'b0, 1'b1, 2'd2, 10);
        mem1[6] = 3'd3; mem1[24] = 3'd3;
        run_op("t11", pair(6, 24), '0, 1'b0, 1'b1, 2'd3, 11);
        chk("rd_addr_idle_zero", addr_bad, 0);

        // 4x8, RD_LAT=3: abort in WALK by reset, then a clean rerun.
        mem2[9] = 3'd1; mem2[11] = 3'd1;
        @(negedge clk);
        sel2 = '0; sel2[9] = 1'b1; sel2[11] = 1'b1;
        hid2 = '0; hid2[1] = 1'b1; hid2[3] = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (7) @(negedge clk);
        chk("t6_inwalk", {busy2, rd_en2, ms2, mf2}, 4'b1000);
        #1 rst2 = 1'b1;
        #1 chk("t6_rst_outs", {busy2, ms2, mf2, rd_en2, dir2, rd_addr2, c20, c21}, 0);
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        pulses = 0;
        repeat (BOUND2) begin
            @(negedge clk);
            if (ms2 || mf2 || busy2) pulses++;
        end
        chk("t6_no_pulse", pulses, 0);

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        sel2 = '0; hid2 = '0;
        cyc = 1;
        while (!(ms2 || mf2) && cyc < BOUND2 + 4) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_cycles", cyc, 12);
        chk("t6_ms", ms2, 1);
        chk("t6_dir", dir2, 0);
        chk("t6_c0", c20, 9);
        chk("t6_c1", c21, 11);
        @(negedge clk);
        chk("t6_after", {busy2, ms2, mf2}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
